adder_scheduler: RTL and testbench

Sequencer and round-robin arbiter that shares one 64-bit `RecursiveDoubling` adder among `NREQ` requesters. The adder's sum output combines live operands with a carry vector delayed by 8 register stages, so operands must be held stable for the full pipeline depth. This block grants one requester at a time and holds its operands in registers. It counts out the adder latency, captures sum and carry-out, and returns them on a single tagged response channel. It sits between the requesting units and the adder, and is the only legal driver of the adder's inputs.

---
 rtl/adder_scheduler_pkg.sv | 7 +
 rtl/adder_scheduler_adder.sv | 27 ++
 rtl/adder_scheduler_arb.sv | 22 ++
 rtl/adder_scheduler.sv | 98 +++++++++
 tb/tb_adder_scheduler.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/adder_scheduler_pkg.sv
// adder_scheduler_pkg: shared constants and state encoding for the adder scheduler.
package adder_scheduler_pkg;
    localparam int ADD_W   = 64;
    localparam int ADD_LAT = 8;
    localparam int CNT_W   = 4;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
endpackage

// File: rtl/adder_scheduler_adder.sv
// RecursiveDoubling: parallel-prefix adder; carries pass 8 register stages, sum uses live operands.
module RecursiveDoubling #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] s_o,
    output logic         ca_o
);
    localparam int LV = $clog2(W);
    logic [W-1:0] g_q [LV+1];
    logic [W-1:0] p_q [LV+1];
    logic [W-1:0] c_q;
    // Zero-fill on the shifts is correct here since carry-in is always 0.
    always_ff @(posedge clk) begin
        g_q[0] <= a_i & b_i;
        p_q[0] <= a_i ^ b_i;
        for (int l = 0; l < LV; l++) begin
            g_q[l+1] <= g_q[l] | (p_q[l] & (g_q[l] << (1 << l)));
            p_q[l+1] <= p_q[l] & (p_q[l] << (1 << l));
        end
        c_q <= g_q[LV];
    end
    assign s_o  = a_i ^ b_i ^ {c_q[W-2:0], 1'b0};
    assign ca_o = c_q[W-1];
endmodule

// File: rtl/adder_scheduler_arb.sv
// rr_arbiter: combinational round-robin pick, highest priority at last+1.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);
    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        grant = '0;
        grant_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NREQ]) begin
                grant = NREQ'(1) << ((int'(last) + k) % NREQ);
                grant_idx = IDW'((int'(last) + k) % NREQ);
            end
        end
    end
endmodule

// File: rtl/adder_scheduler.sv
// adder_scheduler: round-robin sequencer sharing one pipelined 64-bit adder among NREQ requesters.
module adder_scheduler
    import adder_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ADD_W-1:0] req_a,
    input  logic [NREQ*ADD_W-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [ADD_W-1:0]      resp_sum,
    output logic                  resp_carry,
    output logic                  busy
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]     last_q, last_d, op_id_q, op_id_d, resp_id_q, resp_id_d, gidx;
    logic [ADD_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d, sum_q, sum_d, add_s;
    logic               carry_q, carry_d, add_ca, take;
    logic [NREQ-1:0]    grant;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req(req_valid), .last(last_q), .grant(grant), .grant_idx(gidx)
    );

    // Operand registers are the adder's only source and change only on a grant edge.
    RecursiveDoubling #(.W(ADD_W)) u_add (
        .clk(clk), .a_i(op_a_q), .b_i(op_b_q), .s_o(add_s), .ca_o(add_ca)
    );

    assign take       = !reset && (state_q == IDLE || (state_q == RESP && resp_ready));
    assign req_ready  = take ? grant : '0;
    assign busy       = state_q != IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_id    = resp_id_q;
    assign resp_sum   = sum_q;
    assign resp_carry = carry_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        op_id_d   = op_id_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        resp_id_d = resp_id_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        if (state_q == BUSY) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ADD_LAT)) begin
                state_d   = RESP;
                sum_d     = add_s;
                carry_d   = add_ca;
                resp_id_d = op_id_q;
            end
        end
        if (state_q == RESP && resp_ready) state_d = IDLE;
        if (take && |req_valid) begin
            state_d = BUSY;
            cnt_d   = '0;
            last_d  = gidx;
            op_id_d = gidx;
            op_a_d  = req_a[gidx*ADD_W +: ADD_W];
            op_b_d  = req_b[gidx*ADD_W +: ADD_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= IDW'(NREQ - 1);
            op_id_q   <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            resp_id_q <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            op_id_q   <= op_id_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            resp_id_q <= resp_id_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
        end
    end
endmodule

// File: tb/tb_adder_scheduler.sv
// tb_adder_scheduler: directed stimulus with a scoreboard queue checked by a response monitor.
module tb_adder_scheduler;
    localparam int NREQ = 4;
    typedef struct packed { logic [1:0] id; logic [63:0] sum; logic carry; } exp_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 resp_ready = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*64-1:0]   req_a = '0;
    logic [NREQ*64-1:0]   req_b = '0;
    logic                 resp_valid, resp_carry, busy;
    logic [1:0]           resp_id;
    logic [63:0]          resp_sum;
    exp_t                 sb[$];
    exp_t                 e;
    int                   n_cmp = 0;
    int                   n_fail = 0;

    adder_scheduler #(.NREQ(NREQ), .IDW(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_sum(resp_sum), .resp_carry(resp_carry), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic put(int id, logic [63:0] a, logic [63:0] b, logic [63:0] s, logic c);
        req_a[id*64 +: 64] = a;
        req_b[id*64 +: 64] = b;
        sb.push_back(exp_t'{id: 2'(id), sum: s, carry: c});
    endtask

    // Counts negedges from the grant sample until resp_valid appears (bounded).
    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic single(int id, logic [63:0] a, logic [63:0] b, logic [63:0] s, logic c);
        int lat;
        @(posedge clk); #1;
        put(id, a, b, s, c);
        req_valid[id] = 1'b1;
        @(negedge clk);
        chk("grant", 64'(req_ready), 64'(1) << id);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        wait_resp(lat);
        chk("latency", 64'(lat), 64'd10);
        @(posedge clk); #1;
    endtask

    // Drops each request after its grant and scrambles its operands while BUSY.
    task automatic serve(int n, int ord[4], bit space);
        int got = 0;
        int last_rc = -1;
        bit done = 1'b0;
        logic [NREQ-1:0] gr;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            gr = req_valid & req_ready;
            if (gr != 0) begin
                if (got < n) chk("grant_order", 64'(gr), 64'(1) << ord[got]);
                got++;
            end
            if (resp_valid && resp_ready) begin
                if (space && last_rc >= 0) chk("resp_spacing", 64'(c - last_rc), 64'd10);
                last_rc = c;
            end
            if (req_valid == 0 && !busy && !resp_valid) done = 1'b1;
            else begin
                @(posedge clk); #1;
                req_valid = req_valid & ~gr;
                for (int i = 0; i < NREQ; i++)
                    if (gr[i]) begin
                        req_a[i*64 +: 64] = {$urandom, $urandom};
                        req_b[i*64 +: 64] = {$urandom, $urandom};
                    end
            end
        end
        chk("serve_done", 64'(done), 64'd1);
        chk("grant_count", 64'(got), 64'(n));
    endtask

    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_resp: id %0d sum %0h with nothing expected", resp_id, resp_sum);
            end else begin
                e = sb.pop_front();
                chk("resp_id", 64'(resp_id), 64'(e.id));
                chk("resp_sum", resp_sum, e.sum);
                chk("resp_carry", 64'(resp_carry), 64'(e.carry));
            end
        end
    end

    initial begin
        int lat;
        bit stray;
        req_valid = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_sum", resp_sum, 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_carry", 64'(resp_carry), 64'd0);
        @(posedge clk); #1;
        req_valid = '0;
        reset = 1'b0;

        single(2, 64'd1, 64'd1, 64'd2, 1'b0);

        @(posedge clk); #1;
        put(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
        put(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0);
        req_valid = 4'b1001;
        serve(2, '{3, 0, 0, 0}, 1'b0);

        @(posedge clk); #1;
        reset = 1'b1;
        put(0, 64'd5, 64'd7, 64'd12, 1'b0);
        put(1, 64'hFFFF_0000_0000_0000, 64'h0001_0000_0000_0000, 64'd0, 1'b1);
        put(2, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h2222_2222_2222_2211, 1'b0);
        put(3, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        req_valid = 4'hF;
        @(negedge clk);
        chk("req_ready_in_reset", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        serve(4, '{0, 1, 2, 3}, 1'b1);

        @(posedge clk); #1;
        resp_ready = 1'b0;
        put(1, 64'd3, 64'd4, 64'd7, 1'b0);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("bp_grant", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        put(0, 64'd10, 64'd20, 64'd30, 1'b0);
        wait_resp(lat);
        chk("bp_latency", 64'(lat), 64'd10);
        @(posedge clk); #1;
        req_valid = 4'b0001;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_id", 64'(resp_id), 64'd1);
            chk("bp_sum", resp_sum, 64'd7);
            chk("bp_carry", 64'(resp_carry), 64'd0);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        serve(1, '{0, 0, 0, 0}, 1'b0);

        @(posedge clk); #1;
        req_a[2*64 +: 64] = 64'd100;
        req_b[2*64 +: 64] = 64'd200;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("abort_grant", 64'(req_ready), 64'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_resp_valid", 64'(resp_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd0);
        chk("abort_resp_sum", resp_sum, 64'd0);
        chk("abort_resp_id", 64'(resp_id), 64'd0);
        chk("abort_resp_carry", 64'(resp_carry), 64'd0);
        stray = 1'b0;
        repeat (12) begin
            @(negedge clk);
            stray = stray | resp_valid;
        end
        chk("abort_no_stray", 64'(stray), 64'd0);

        single(1, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 64'hDEAD_BEF0_0000_0000, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
